division_ip: RTL and testbench
==============================

DIVISION_IP -- requirements
Module: division_ip

Interface
REQ-001 No parameters; all widths are fixed by package constants (REQ-021).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 s_axis_divisor_tvalid  input  1  divisor sample valid.
REQ-005 s_axis_divisor_tdata  input  16  divisor, two's complement.
REQ-006 s_axis_dividend_tvalid  input  1  dividend sample valid.
REQ-007 s_axis_dividend_tdata  input  16  dividend, two's complement.
REQ-008 m_axis_dout_tvalid  output  1  result valid, one-cycle pulse per result.
REQ-009 m_axis_dout_tdata  output  24  result: [23:8] integer quotient Q, [7:0] signed fraction F.
REQ-010 No tready on any channel.
- The block never stalls.
- Downstream always accepts.

Function
REQ-011 An operation is accepted on a rising edge where both tvalids are 1.
- If only one tvalid is 1, both samples are dropped with no output.
- No per-channel buffering.
REQ-012 Throughput is one operation per cycle, fully pipelined.
- Results emerge in acceptance order.
- Input-to-output latency is exactly 25 cycles: accepted at edge N, tvalid=1 and tdata valid after edge N+25.
REQ-013 Q = dividend/divisor truncated toward zero, 16-bit two's complement.
REQ-014 F is Q1.7 two's complement (range -1 to +127/128), sign equal to sign(dividend) XOR sign(divisor).
- |F| = floor(|R|*128/|divisor|), where R is the truncating remainder.
- F = 0 when R = 0.
REQ-015 Magnitudes are computed as 16-bit unsigned, so |-32768| = 32768 is exact.
- Use restoring or non-restoring division: 16 integer steps plus 7 fraction steps.
REQ-016 Overflow: -32768 / -1 produces Q = 0x8000, F = 0x00 (wraps, no saturation).
REQ-017 Divide by zero:
- Q = 0x7FFF if dividend >= 0, else Q = 0x8000.
- F = 0x00.
REQ-018 When m_axis_dout_tvalid = 0, m_axis_dout_tdata = 0.

Reset
REQ-019 While rst = 1 at an edge:
- All pipeline valid bits clear.
- m_axis_dout_tvalid = 0 and m_axis_dout_tdata = 0 after that edge.
REQ-020 Reset mid-operation discards all in-flight operations.
- No result for any operation accepted before or during reset is ever emitted.
- An operation accepted on the first edge after rst falls emerges 25 cycles later.

Configuration
REQ-021 Macro DIVISION_IP_DIVBYZERO_EN, when defined, adds output port m_axis_dout_tuser (1 bit).
- m_axis_dout_tuser = 1 alongside a result whose divisor was 0; otherwise 0.
- m_axis_dout_tuser = 0 in reset and whenever tvalid = 0.
REQ-022 Without the macro the port does not exist; REQ-017 data behaviour is unchanged.

Structure
REQ-023 Package division_ip_pkg holds DIV_W=16, FRAC_W=8, FRAC_BITS=7, LATENCY=25, and the result typedef (struct of Q[15:0], F[7:0]).
REQ-024 One sub-module division_ip_stage: a single conditional-subtract step (partial remainder in, quotient bit out), instantiated 23 times between the input stage (abs/sign capture) and the output stage (sign apply, zero/overflow override).

Verification
REQ-025 100 / 7 -> tdata = 0x000E24 (Q=14, F=36) exactly 25 cycles later, tvalid high for 1 cycle.
REQ-026 -7 / 2 and 7 / -2 -> both 0xFFFDC0.
- 7 / 2 -> 0x000340.
- -32768 / -1 -> 0x800000.
REQ-027 5 / 0 -> 0x7FFF00; -5 / 0 -> 0x800000.
- With DIVISION_IP_DIVBYZERO_EN, tuser = 1 on both and 0 on a following 6 / 3 (0x000200).
REQ-028 30 back-to-back random operations:
- Outputs are contiguous, in order, and match the reference model.
- Divisor tvalid alone for 5 cycles yields no outputs.
REQ-029 rst pulsed 10 cycles after 10 accepted operations:
- No output ever appears for those 10.
- A new 9 / 3 issued after reset returns 0x000300 exactly 25 cycles later.

Source files
------------

// File: rtl/division_ip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : division_ip_pkg
//  Description : Widths, latency and shared types for the pipelined divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package division_ip_pkg;

    localparam int DIV_W     = 16;
    localparam int FRAC_W    = 8;
    localparam int FRAC_BITS = 7;
    localparam int LATENCY   = 25;
    localparam int STEPS     = DIV_W + FRAC_BITS;

    typedef struct packed {
        logic [DIV_W-1:0]  q;
        logic [FRAC_W-1:0] f;
    } result_t;

    // num starts as {|dividend|, 0...}; each step shifts one quotient bit in
    // at the bottom, so after STEPS steps it holds {|Q|, |F|}.
    typedef struct packed {
        logic             valid;
        logic             neg;
        logic             dd_neg;
        logic             dz;
        logic [DIV_W-1:0] divisor;
        logic [DIV_W-1:0] rem;
        logic [STEPS-1:0] num;
    } pipe_t;

    function automatic logic [DIV_W-1:0] abs_mag(input logic [DIV_W-1:0] x);
        return x[DIV_W-1] ? -x : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/division_ip_if.sv
`default_nettype none
// ============================================================================
//  Module      : division_ip_if
//  Description : Divisor/dividend input streams and result output stream.
//                m_axis_dout_tuser exists only with DIVISION_IP_DIVBYZERO_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
interface division_ip_if;
    import division_ip_pkg::*;

    logic                      s_axis_divisor_tvalid;
    logic [DIV_W-1:0]          s_axis_divisor_tdata;
    logic                      s_axis_dividend_tvalid;
    logic [DIV_W-1:0]          s_axis_dividend_tdata;
    logic                      m_axis_dout_tvalid;
    logic [DIV_W+FRAC_W-1:0]   m_axis_dout_tdata;
`ifdef DIVISION_IP_DIVBYZERO_EN
    logic                      m_axis_dout_tuser;
`endif

    modport master (
        output s_axis_divisor_tvalid,
        output s_axis_divisor_tdata,
        output s_axis_dividend_tvalid,
        output s_axis_dividend_tdata,
`ifdef DIVISION_IP_DIVBYZERO_EN
        input  m_axis_dout_tuser,
`endif
        input  m_axis_dout_tvalid,
        input  m_axis_dout_tdata
    );

    modport slave (
        input  s_axis_divisor_tvalid,
        input  s_axis_divisor_tdata,
        input  s_axis_dividend_tvalid,
        input  s_axis_dividend_tdata,
`ifdef DIVISION_IP_DIVBYZERO_EN
        output m_axis_dout_tuser,
`endif
        output m_axis_dout_tvalid,
        output m_axis_dout_tdata
    );

endinterface
`default_nettype wire

// File: rtl/division_ip_stage.sv
`default_nettype none
// ============================================================================
//  Module      : division_ip_stage
//  Description : One restoring-division step: shift in a bit, subtract the
//                divisor if it fits, emit the quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module division_ip_stage
    import division_ip_pkg::*;
(
    input  logic [DIV_W-1:0] i_rem,
    input  logic             i_bit,
    input  logic [DIV_W-1:0] i_divisor,
    output logic [DIV_W-1:0] o_rem,
    output logic             o_q
);

    logic [DIV_W-1:0] w_shift_lo;

    // The incoming remainder is below a divisor of at most 2^15, so the low
    // 16 bits of the difference are exact whenever the subtract is taken.
    assign w_shift_lo = {i_rem[DIV_W-2:0], i_bit};
    assign o_q        = ({i_rem, i_bit} >= {1'b0, i_divisor});
    assign o_rem      = o_q ? (w_shift_lo - i_divisor) : w_shift_lo;

endmodule
`default_nettype wire

// File: rtl/division_ip.sv
`default_nettype none
// ============================================================================
//  Module      : division_ip
//  Description : Fully pipelined 16/16 signed divider producing Q and a Q1.7
//                fraction, 25-cycle latency. DIVISION_IP_DIVBYZERO_EN adds
//                a divide-by-zero flag on m_axis_dout_tuser.
//  Revision    : 1.0 - initial release
// ============================================================================
module division_ip
    import division_ip_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    division_ip_if.slave bus
);

    localparam logic [DIV_W-1:0] c_q_max = {1'b0, {(DIV_W-1){1'b1}}};
    localparam logic [DIV_W-1:0] c_q_min = {1'b1, {(DIV_W-1){1'b0}}};

    logic             r_acc_valid;
    logic [DIV_W-1:0] r_acc_dividend;
    logic [DIV_W-1:0] r_acc_divisor;

    always_ff @(posedge clk) begin
        r_acc_dividend <= bus.s_axis_dividend_tdata;
        r_acc_divisor  <= bus.s_axis_divisor_tdata;
        if (rst) begin
            r_acc_valid <= 1'b0;
        end else begin
            r_acc_valid <= bus.s_axis_divisor_tvalid & bus.s_axis_dividend_tvalid;
        end
    end

    pipe_t r_pipe0;

    always_ff @(posedge clk) begin
        r_pipe0.valid   <= r_acc_valid;
        r_pipe0.neg     <= r_acc_dividend[DIV_W-1] ^ r_acc_divisor[DIV_W-1];
        r_pipe0.dd_neg  <= r_acc_dividend[DIV_W-1];
        r_pipe0.dz      <= (r_acc_divisor == '0);
        r_pipe0.divisor <= abs_mag(r_acc_divisor);
        r_pipe0.rem     <= '0;
        r_pipe0.num     <= {abs_mag(r_acc_dividend), {FRAC_BITS{1'b0}}};
        if (rst) begin
            r_pipe0.valid <= 1'b0;
        end
    end

    pipe_t w_pipe [0:STEPS];
    assign w_pipe[0] = r_pipe0;

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        logic [DIV_W-1:0] w_rem;
        logic             w_q;
        pipe_t            r_stage;

        division_ip_stage u_stage (
            .i_rem     (w_pipe[i].rem),
            .i_bit     (w_pipe[i].num[STEPS-1]),
            .i_divisor (w_pipe[i].divisor),
            .o_rem     (w_rem),
            .o_q       (w_q)
        );

        always_ff @(posedge clk) begin
            r_stage     <= w_pipe[i];
            r_stage.rem <= w_rem;
            r_stage.num <= {w_pipe[i].num[STEPS-2:0], w_q};
            if (rst) begin
                r_stage.valid <= 1'b0;
            end
        end

        assign w_pipe[i+1] = r_stage;
    end

    pipe_t             w_last;
    logic [DIV_W-1:0]  w_q_out;
    logic [FRAC_W-1:0] w_f_mag;
    logic [FRAC_W-1:0] w_f_out;

    assign w_last = w_pipe[STEPS];

    // Magnitude -32768 negated stays 0x8000, giving the required wrap.
    always_comb begin
        w_q_out = w_last.num[STEPS-1:FRAC_BITS];
        w_f_mag = {1'b0, w_last.num[FRAC_BITS-1:0]};
        w_f_out = w_f_mag;
        if (w_last.dz) begin
            w_q_out = w_last.dd_neg ? c_q_min : c_q_max;
            w_f_out = '0;
        end else if (w_last.neg) begin
            w_q_out = -w_last.num[STEPS-1:FRAC_BITS];
            w_f_out = -w_f_mag;
        end
    end

    logic    r_out_valid;
    result_t r_result;

    always_ff @(posedge clk) begin
        if (rst || !w_last.valid) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            r_out_valid <= 1'b1;
            r_result    <= '{q: w_q_out, f: w_f_out};
        end
    end

    assign bus.m_axis_dout_tvalid = r_out_valid;
    assign bus.m_axis_dout_tdata  = r_result;

`ifdef DIVISION_IP_DIVBYZERO_EN
    logic r_out_dz;

    always_ff @(posedge clk) begin
        if (rst || !w_last.valid) begin
            r_out_dz <= 1'b0;
        end else begin
            r_out_dz <= w_last.dz;
        end
    end

    assign bus.m_axis_dout_tuser = r_out_dz;
`endif

endmodule
`default_nettype wire

// File: tb/tb_division_ip.sv
`default_nettype none
// ============================================================================
//  Module      : tb_division_ip
//  Description : Self-checking bench for division_ip against an arithmetic
//                reference model with a due-cycle scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_division_ip;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    division_ip_if bus ();

    division_ip dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          due;
        logic [23:0] data;
        logic        dz;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    function automatic logic [23:0] model(input logic [15:0] a, input logic [15:0] b);
        int ia, ib, iq, ir, fm, fv;
        logic [15:0] q16;
        logic [7:0]  f8;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (ib == 0) begin
            q16 = (ia >= 0) ? 16'h7FFF : 16'h8000;
            f8  = 8'h00;
        end else begin
            iq  = ia / ib;
            ir  = ia % ib;
            fm  = ((ir < 0 ? -ir : ir) * 128) / (ib < 0 ? -ib : ib);
            fv  = ((ia < 0) != (ib < 0)) ? -fm : fm;
            q16 = iq[15:0];
            f8  = fv[7:0];
        end
        return {q16, f8};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) q.delete();
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("valid", 32'(bus.m_axis_dout_tvalid), 32'd1);
            check("data", 32'(bus.m_axis_dout_tdata), 32'(e.data));
`ifdef DIVISION_IP_DIVBYZERO_EN
            check("tuser", 32'(bus.m_axis_dout_tuser), 32'(e.dz));
`endif
        end else begin
            check("idle_valid", 32'(bus.m_axis_dout_tvalid), 32'd0);
            check("idle_data", 32'(bus.m_axis_dout_tdata), 32'd0);
`ifdef DIVISION_IP_DIVBYZERO_EN
            check("idle_tuser", 32'(bus.m_axis_dout_tuser), 32'd0);
`endif
        end
    endtask

    task automatic drive(input logic vs, input logic [15:0] dv, input logic vd, input logic [15:0] dd);
        exp_t e;
        bus.s_axis_divisor_tvalid  = vs;
        bus.s_axis_divisor_tdata   = dv;
        bus.s_axis_dividend_tvalid = vd;
        bus.s_axis_dividend_tdata  = dd;
        tick();
        if (vs && vd && !rst) begin
            e.due  = cyc + 25;
            e.data = model(dd, dv);
            e.dz   = (dv == 16'h0000);
            q.push_back(e);
        end
    endtask

    task automatic op(input int dividend, input int divisor);
        drive(1'b1, divisor[15:0], 1'b1, dividend[15:0]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    initial begin
        logic [15:0] rdd, rdv;

        bus.s_axis_divisor_tvalid  = 1'b0;
        bus.s_axis_divisor_tdata   = '0;
        bus.s_axis_dividend_tvalid = 1'b0;
        bus.s_axis_dividend_tdata  = '0;

        // Reset state.
        idle(3);
        rst = 1'b0;

        // Model sanity against hand-computed values.
        check("model_100_7", 32'(model(16'd100, 16'd7)), 32'h000E24);
        check("model_m7_2", 32'(model(-16'sd7, 16'd2)), 32'hFFFDC0);

        op(100, 7);
        idle(30);

        op(-7, 2);
        op(7, -2);
        op(7, 2);
        op(-32768, -1);
        op(5, 0);
        op(-5, 0);
        op(6, 3);
        op(32767, -32768);
        op(-32768, 3);
        idle(30);

        for (int k = 0; k < 30; k++) begin
            rdd = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       rdv = 16'h0000;
                1, 2:    rdv = 16'($urandom_range(1, 20));
                3:       rdv = -16'($urandom_range(1, 20));
                default: rdv = 16'($urandom);
            endcase
            drive(1'b1, rdv, 1'b1, rdd);
        end
        idle(30);

        // Lone valids must be dropped.
        for (int k = 0; k < 5; k++) drive(1'b1, 16'd3, 1'b0, 16'd9);
        for (int k = 0; k < 3; k++) drive(1'b0, 16'd3, 1'b1, 16'd9);
        idle(30);

        // In-flight operations are discarded by reset.
        for (int k = 0; k < 10; k++) op(k * 100 + 1, k + 1);
        idle(10);
        rst = 1'b1;
        idle(2);
        op(50, 5);
        rst = 1'b0;
        op(9, 3);
        idle(40);

        check("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
